// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the hex counter datapath and the digit scan scheduler.
// The datapath is the master; the scan controller is the slave that drives the SEG pins.
interface seg_scan_ctrl_if;
   logic [15:0] value;
   logic        update;
   logic [3:0]  digit_en;
   logic [3:0]  dp_en;
   logic        lzb;
   logic [11:0] seg;
   logic        frame_done;

   modport master (
      output value, update, digit_en, dp_en, lzb,
      input  seg, frame_done
   );

   modport slave (
      input  value, update, digit_en, dp_en, lzb,
      output seg, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan scheduler with per-slot blanking gap,
// leading-zero blanking and frame-aligned (tear-free) value updates.
module seg_scan_ctrl #(
   parameter int CLK_DIV   = 100000,
   parameter int BLANK_CYC = 1000
) (
   input logic            clk,
   input logic            rst_n,
   seg_scan_ctrl_if.slave bus
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYC);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_ON    = 1'b1;

   logic [CW-1:0] cnt, cnt_next;
   logic [1:0]    idx, idx_next;
   logic [0:0]    phase_next;
   logic [15:0]   shadow, active, active_next;
   logic          pending;
   logic          wrap;
   logic [11:0]   seg_q, seg_next;
   logic          frame_done_q, frame_done_next;
   logic [3:0]    nibble;
   logic          lead_zero;
   logic [3:0]    anodes;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_comb begin
      cnt_next = cnt + CW'(1);
      idx_next = idx;
      if (cnt == CNT_LAST) begin
         cnt_next = '0;
         idx_next = idx + 2'd1;
      end
   end

   // The output register is loaded with the content for the slot position being
   // entered, so SEG lines up with cnt/idx rather than lagging them by a cycle.
   assign wrap            = (idx == 2'd3) && (cnt == CNT_LAST);
   assign active_next     = (wrap && pending) ? shadow : active;
   assign phase_next      = (cnt_next >= CNT_ON) ? ST_ON : ST_BLANK;
   assign frame_done_next = (idx_next == 2'd3) && (cnt_next == CNT_LAST);

   always_comb begin
      nibble = active_next[{idx_next, 2'b00} +: 4];
      anodes = ~(4'b0001 << idx_next);
      case (idx_next)
         2'd1:    lead_zero = bus.lzb && (active_next[15:4] == 12'h000);
         2'd2:    lead_zero = bus.lzb && (active_next[15:8] == 8'h00);
         2'd3:    lead_zero = bus.lzb && (active_next[15:12] == 4'h0);
         default: lead_zero = 1'b0;
      endcase
      seg_next = 12'hFFF;
      if (phase_next == ST_ON && bus.digit_en[idx_next]) begin
         if (lead_zero) begin
            if (bus.dp_en[idx_next]) seg_next = {anodes, 1'b0, 7'h7F};
         end else begin
            seg_next = {anodes, ~bus.dp_en[idx_next], hex7(nibble)};
         end
      end
   end

   // A fresh UPDATE always leaves a pending value, even on the wrap cycle where
   // the previous shadow is the one being transferred.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         idx          <= 2'd0;
         shadow       <= 16'h0000;
         active       <= 16'h0000;
         pending      <= 1'b0;
         seg_q        <= 12'hFFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         idx          <= idx_next;
         active       <= active_next;
         seg_q        <= seg_next;
         frame_done_q <= frame_done_next;
         if (bus.update) begin
            shadow  <= bus.value;
            pending <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts SEG and
// FRAME_DONE every cycle; a monitor pops and compares on each falling edge.
module tb_seg_scan_ctrl;

   localparam int CLK_DIV   = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = 4 * CLK_DIV;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   seg_scan_ctrl_if bus();

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int          check_count = 0;
   int          pass_count  = 0;
   int          m_pos       = 0;
   logic [15:0] m_active    = 16'h0000;
   logic [15:0] m_shadow    = 16'h0000;
   logic        m_pending   = 1'b0;
   logic [12:0] exp_q [$];

   task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] required);
      check_count++;
      if (actual === required) pass_count++;
      else $display("[TB] FAIL %s: got %03h, expected %03h (pos %0d, t=%0t)", name, actual, required, m_pos, $time);
   endtask

   // Display content from slot arithmetic; the dp bit is active-low, so a disabled dp reads as 1.
   function automatic logic [11:0] model_seg(input int pos, input logic [15:0] act,
                                             input logic [3:0] den, input logic [3:0] dpen,
                                             input logic lz);
      int         slot  = pos / CLK_DIV;
      int         off   = pos % CLK_DIV;
      int         upper = int'(act) >> (4 * slot);
      int         nib   = upper % 16;
      logic [3:0] an    = 4'(15 - (1 << slot));
      if (off < BLANK_CYC || !den[slot]) return 12'hFFF;
      if (lz && slot > 0 && upper == 0) return dpen[slot] ? {an, 1'b0, 7'h7F} : 12'hFFF;
      return {an, ~dpen[slot], hex_tab[nib]};
   endfunction

   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (m_pos == FRAME - 1 && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
         end
         if (bus.update) begin
            m_shadow  = bus.value;
            m_pending = 1'b1;
         end
         m_pos = (m_pos + 1) % FRAME;
         exp_q.push_back({model_seg(m_pos, m_active, bus.digit_en, bus.dp_en, bus.lzb),
                          1'(m_pos == FRAME - 1)});
      end
   end

   always @(negedge clk) begin
      logic [12:0] e;
      if (rst_n === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard: got output with no expectation queued (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            checkOutput("seg", bus.seg, e[12:1]);
            checkOutput("frame_done", {11'b0, bus.frame_done}, {11'b0, e[0]});
         end
      end
   end

   task automatic applyReset();
      rst_n = 1'b0;
      #1;
      checkOutput("reset_seg", bus.seg, 12'hFFF);
      checkOutput("reset_frame_done", {11'b0, bus.frame_done}, 12'h000);
      m_pos     = 0;
      m_active  = 16'h0000;
      m_shadow  = 16'h0000;
      m_pending = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      checkOutput("reset_hold_seg", bus.seg, 12'hFFF);
      #2 rst_n = 1'b1;
   endtask

   task automatic waitPos(input int pos);
      bit found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         @(negedge clk);
         if (m_pos == pos) found = 1'b1;
      end
      if (!found) begin
         check_count++;
         $display("[TB] FAIL wait_pos: position %0d not reached, got %0d", pos, m_pos);
      end
   endtask

   task automatic expectAt(input int pos, input logic [11:0] val, input string name);
      waitPos(pos);
      checkOutput(name, bus.seg, val);
   endtask

   task automatic applyStimulus(input int pos, input logic [15:0] val);
      waitPos(pos);
      bus.value  = val;
      bus.update = 1'b1;
      @(negedge clk);
      bus.update = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
      rst_n        = 1'b1;
      bus.value    = 16'h0000;
      bus.update   = 1'b0;
      bus.digit_en = 4'hF;
      bus.dp_en    = 4'h0;
      bus.lzb      = 1'b0;
      #3;
      applyReset();

      expectAt(1, 12'hFFF, "first_blank");
      expectAt(2, 12'hEC0, "first_digit0");
      expectAt(9, 12'hFFF, "slot1_blank");
      expectAt(10, 12'hDC0, "first_digit1");

      applyStimulus(3, 16'h1234);
      expectAt(26, 12'h7C0, "no_tear_digit3");
      expectAt(2, 12'hE99, "upd_digit0");
      expectAt(10, 12'hDB0, "upd_digit1");
      expectAt(18, 12'hBA4, "upd_digit2");
      expectAt(26, 12'h7F9, "upd_digit3");

      bus.lzb = 1'b1;
      applyStimulus(4, 16'h0050);
      waitPos(0);
      expectAt(2, 12'hEC0, "lzb_digit0");
      expectAt(10, 12'hD92, "lzb_digit1");
      expectAt(18, 12'hFFF, "lzb_digit2");
      expectAt(26, 12'hFFF, "lzb_digit3");
      applyStimulus(4, 16'h0000);
      waitPos(0);
      expectAt(2, 12'hEC0, "lzb_zero_digit0");
      expectAt(10, 12'hFFF, "lzb_zero_digit1");
      bus.dp_en = 4'b0100;
      expectAt(18, 12'hB7F, "lzb_dp_digit2");

      bus.lzb      = 1'b0;
      bus.dp_en    = 4'h0;
      bus.digit_en = 4'b0101;
      expectAt(26, 12'hFFF, "den_digit3");
      expectAt(2, 12'hEC0, "den_digit0");
      expectAt(10, 12'hFFF, "den_digit1");
      expectAt(18, 12'hBC0, "den_digit2");

      bus.digit_en = 4'hF;
      applyStimulus(4, 16'h1111);
      applyStimulus(12, 16'h2222);
      expectAt(2, 12'hEA4, "last_update_wins");
      applyStimulus(31, 16'h3333);
      expectAt(2, 12'hEA4, "wrap_update_delayed");
      expectAt(2, 12'hEB0, "wrap_update_applied");

      waitPos(20);
      #2;
      applyReset();
      expectAt(1, 12'hFFF, "restart_blank");
      expectAt(2, 12'hEC0, "restart_digit0");
      expectAt(10, 12'hDC0, "restart_digit1");
      expectAt(26, 12'h7C0, "restart_digit3");

      repeat (800) begin
         @(negedge clk);
         bus.update = 1'b0;
         if ($urandom_range(15) == 0) begin
            bus.value  = 16'($urandom) & masks[$urandom_range(4)];
            bus.update = 1'b1;
         end
         if ($urandom_range(39) == 0) begin
            bus.digit_en = 4'($urandom);
            bus.dp_en    = 4'($urandom);
            bus.lzb      = 1'($urandom);
         end
      end
      @(negedge clk);
      bus.update = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
